// File: rtl/ma_stage_pkg.sv
// ma_stage_pkg: shared payload type and constants for the MEM->WB stage register
package ma_stage_pkg;
    localparam int DATA_LEN = 32;
    localparam int ADDRESS_LEN_REG_FILE = 4;
    typedef struct packed {
        logic                            WB_EN;
        logic                            MEM_R_EN;
        logic [DATA_LEN-1:0]             ALU_Res;
        logic [DATA_LEN-1:0]             MEM_OUT;
        logic [ADDRESS_LEN_REG_FILE-1:0] Dest;
    } ma_wb_payload_t;
    localparam ma_wb_payload_t MA_WB_PAYLOAD_RST = '0;
endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one valid bit plus payload register with load and clear
// Ports: clk, rst (sync active-low), ld (capture d, set valid), clr (drop valid,
// wins over ld), d (payload in), vld (slot holds an entry), q (held payload).
module pipe_skid_slot import ma_stage_pkg::*; #(
    parameter int W = $bits(ma_wb_payload_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld <= 1'b0;
            q   <= W'(MA_WB_PAYLOAD_RST);
        end else begin
            vld <= clr ? 1'b0 : (ld | vld);
            if (ld && !clr) q <= d;
        end
    end
endmodule

// File: rtl/ma_wb_stage_pipe.sv
// ma_wb_stage_pipe: elastic MEM->WB stage register with flush and optional skid slot
// Macro MA_WB_SKID_EN: defined -> two entries, registered in_ready;
// undefined -> one entry, in_ready = ~out_valid | out_ready.
// Ports: clk, rst (sync active-low), flush; upstream in_valid/in_ready with
// WB_EN_in, MEM_R_EN_in, ALU_Res_in, MEM_OUT_in, Dest_in; downstream
// out_valid/out_ready with WB_EN, MEM_R_EN, ALU_Res, MEM_OUT, Dest, WB_Value;
// occupancy = entries held.
module ma_wb_stage_pipe #(
    parameter int DATA_LEN = ma_stage_pkg::DATA_LEN,
    parameter int ADDRESS_LEN_REG_FILE = ma_stage_pkg::ADDRESS_LEN_REG_FILE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            WB_EN_in,
    input  logic                            MEM_R_EN_in,
    input  logic [DATA_LEN-1:0]             ALU_Res_in,
    input  logic [DATA_LEN-1:0]             MEM_OUT_in,
    input  logic [ADDRESS_LEN_REG_FILE-1:0] Dest_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            WB_EN,
    output logic                            MEM_R_EN,
    output logic [DATA_LEN-1:0]             ALU_Res,
    output logic [DATA_LEN-1:0]             MEM_OUT,
    output logic [ADDRESS_LEN_REG_FILE-1:0] Dest,
    output logic [DATA_LEN-1:0]             WB_Value,
    output logic [1:0]                      occupancy
);
    localparam int PW = 2 + 2 * DATA_LEN + ADDRESS_LEN_REG_FILE;
    logic          acc, pop, m_vld, main_ld, main_clr, wb_q;
    logic [PW-1:0] in_pay, main_d, m_q;
    assign in_pay = {WB_EN_in, MEM_R_EN_in, ALU_Res_in, MEM_OUT_in, Dest_in};
    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;
    // the main slot empties only when popped and nothing refills it
    assign main_clr = flush | (pop & ~main_ld);
`ifdef MA_WB_SKID_EN
    logic          s_vld, refill;
    logic [PW-1:0] s_q;
    assign refill = pop & s_vld;
    assign main_ld = ~flush & (refill | (acc & (~m_vld | pop)));
    assign main_d = refill ? s_q : in_pay;
    // in_ready depends only on flops, so out_ready never reaches it
    assign in_ready = rst & ~s_vld;
    assign occupancy = {1'b0, m_vld} + {1'b0, s_vld};
    pipe_skid_slot #(.W(PW)) u_skid (
        .clk(clk), .rst(rst), .ld(~flush & acc & m_vld & ~pop),
        .clr(flush | refill), .d(in_pay), .vld(s_vld), .q(s_q)
    );
`else
    assign main_ld = ~flush & acc;
    assign main_d = in_pay;
    assign in_ready = rst & (~m_vld | out_ready);
    assign occupancy = {1'b0, m_vld};
`endif
    pipe_skid_slot #(.W(PW)) u_main (
        .clk(clk), .rst(rst), .ld(main_ld), .clr(main_clr),
        .d(main_d), .vld(m_vld), .q(m_q)
    );
    assign {wb_q, MEM_R_EN, ALU_Res, MEM_OUT, Dest} = m_q;
    assign out_valid = m_vld;
    assign WB_EN = wb_q & m_vld;
    assign WB_Value = MEM_R_EN ? MEM_OUT : ALU_Res;
endmodule

// File: doc/ma_wb_stage_pipe.md
# ma_wb_stage_pipe

Parametrised MEM→WB pipeline stage register with a valid/ready elastic handshake, synchronous flush and an optional two-entry skid buffer.
- **Position:** between the memory-access stage and the write-back mux of the ARM pipeline.
- **Role:** successor to the plain free-running stage register. Lets memory stalls back-pressure upstream without losing or duplicating a write-back, and blocks stale entries from writing the register file.

## Interface
Parameters:
- DATA_LEN, 32, width of ALU result and memory read data
- ADDRESS_LEN_REG_FILE, 4, width of destination register index

Ports (clock and reset first):
- clk  input  1  pipeline clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-low
- flush  input  1  discard all held entries this edge
- in_valid  input  1  upstream entry present
- in_ready  output  1  stage can accept this cycle
- WB_EN_in  input  1  entry writes register file
- MEM_R_EN_in  input  1  entry is a load (select MEM_OUT)
- ALU_Res_in  input  DATA_LEN  ALU result
- MEM_OUT_in  input  DATA_LEN  memory read data
- Dest_in  input  ADDRESS_LEN_REG_FILE  destination register
- out_valid  output  1  head entry present
- out_ready  input  1  write-back consumes head this cycle
- WB_EN, MEM_R_EN  output  1  head control bits
- ALU_Res, MEM_OUT  output  DATA_LEN  head data
- Dest  output  ADDRESS_LEN_REG_FILE  head destination
- WB_Value  output  DATA_LEN  MEM_R_EN ? MEM_OUT : ALU_Res
- occupancy  output  2  entries held (0..2; max 1 without skid)

## Operation
- **Handshake:**
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - Payload is the five *_in fields, moved as one unit.
- **Head output gating:**
  - WB_EN output = stored WB_EN & out_valid. An empty stage never requests a write.
  - ALU_Res, MEM_OUT and Dest hold their last value when empty.
- **Two-entry mode (skid compiled in):**
  - Slots: main (drives outputs) and skid.
  - in_ready is registered and equals "skid empty".
  - Accept with main empty, or main popping with skid empty: the entry goes to main.
  - Accept while main is full and not popping: the entry goes to skid.
  - Pop with skid full: skid moves to main. A simultaneous accept is impossible in this case, because in_ready = 0.
  - Pop with no accept and skid empty: main empties.
- **Ordering:** strictly FIFO; no entry is dropped or duplicated.
- **Flush:**
  - Clears both valid bits at the edge; an accept in the same cycle is discarded.
  - Occupancy = 0 and in_ready = 1 on the next cycle.
  - Pop in the flush cycle is permitted: the head is consumed and is not replayed.
- **Reset (rst = 0 at the edge):**
  - All outputs and stored fields become 0: WB_EN, MEM_R_EN, ALU_Res, MEM_OUT, Dest, WB_Value, out_valid, occupancy.
  - in_ready = 0 while rst is low; in_ready = 1 on the first cycle after release.
  - Reset mid-operation discards all held entries.
  - Reset has priority over flush, and flush over the handshake.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 entry per cycle with out_ready held high, in both modes.
- With skid:
  - in_ready falls the cycle after the second entry is captured.
  - in_ready rises the cycle after the skid slot drains.
  - No combinational path from out_ready to in_ready.
- Without skid: in_ready = ~out_valid | out_ready, combinational from out_ready.
- WB_Value is combinational from the head registers; no added latency.

## Configuration
- Macro: MA_WB_SKID_EN.
- **Defined:** two-entry skid behaviour as above; occupancy range 0..2; registered in_ready.
- **Undefined:**
  - Single main slot only; occupancy range 0..1.
  - in_ready is combinational as given in Timing.
  - All other rules are identical (flush, reset, gating).

## Structure
- **Package ma_stage_pkg:**
  - ma_wb_payload_t struct (WB_EN, MEM_R_EN, ALU_Res, MEM_OUT, Dest), sized from package constants DATA_LEN and ADDRESS_LEN_REG_FILE.
  - Reset-value constant MA_WB_PAYLOAD_RST (all zero).
- **Sub-module pipe_skid_slot:**
  - One generic payload-width slot: valid bit plus payload register, with load and clear.
  - Instantiated twice, for main and skid (skid instance under the macro).
  - The top level holds the control logic.

## Test plan
- **Reset then single entry:**
  - Release rst; apply in_valid = 1, ALU_Res_in = 0x0000_00A5, Dest_in = 3, WB_EN_in = 1 for one cycle; out_ready = 1.
  - Next cycle: out_valid = 1, WB_Value = 0xA5, Dest = 3.
  - Cycle after: out_valid = 0, WB_EN = 0.
- **Back-pressure (skid):**
  - Stream entries 1,2,3 with out_ready = 0.
  - Entries 1 and 2 accepted; in_ready = 0 from the cycle after entry 2; occupancy = 2; entry 3 held upstream.
  - Raise out_ready: outputs 1,2,3 in order, one per cycle, none lost.
- **Load select:** MEM_R_EN_in = 1, MEM_OUT_in = 0xDEAD_BEEF, ALU_Res_in = 0x1000 -> WB_Value = 0xDEAD_BEEF.
- **Flush:**
  - With occupancy = 2, assert flush together with in_valid = 1.
  - Next cycle: occupancy = 0, out_valid = 0, WB_EN = 0, in_ready = 1; the flushed-cycle entry never appears.
- **Reset mid-stream:**
  - Pull rst low with occupancy = 1: the next edge zeroes all outputs and in_ready = 0.
  - After release: in_ready = 1 and no stale entry is emitted.
- **Full throughput:** 100 back-to-back entries with out_ready = 1 -> 100 pops in 100 consecutive cycles after 1-cycle latency, in both macro settings.
